// File: rtl/memory_arbiter.sv
// Two-port arbiter and fixed three-cycle access sequencer for the 256x8 system RAM.
// Port 0 (CPU) has priority; a streak counter guarantees port 1 (loader) a grant.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winning port's request
// ACCESS | RAM cycle: write drives bus + mem_ie, read enables mem_oe and samples bus
// ACK    | one-cycle ack pulse to the granted port
module memory_arbiter #(
   parameter int MAX_STREAK = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic [7:0] mem_addr,
   output logic       mem_ie,
   output logic       mem_oe,
   inout  wire  [7:0] bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

   state_t     state;
   state_t     state_nxt;
   logic       any_req;
   logic       g_nxt;
   logic       g;
   logic       we_q;
   logic [7:0] wdata_q;
   logic [2:0] streak;
   logic       drive_bus;

   assign any_req = req0 | req1;
   // port 1 wins when alone or when port 0 has used up its streak
   assign g_nxt   = req1 & (~req0 | (streak == STREAK_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         g        <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= 8'h00;
         mem_addr <= 8'h00;
         streak   <= 3'd0;
         rdata    <= 8'h00;
      end else begin
         if (state == IDLE && any_req) begin
            g        <= g_nxt;
            we_q     <= g_nxt ? we1 : we0;
            wdata_q  <= g_nxt ? wdata1 : wdata0;
            mem_addr <= g_nxt ? addr1 : addr0;
            if (g_nxt || !req1) begin
               streak <= 3'd0;
            end else if (streak != STREAK_MAX) begin
               streak <= streak + 3'd1;
            end
         end
         if (state == ACCESS && !we_q) begin
            rdata <= bus;
         end
      end
   end

   always_comb begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      busy      = 1'b0;
      mem_ie    = 1'b0;
      mem_oe    = 1'b0;
      drive_bus = 1'b0;
      case (state)
         ACCESS: begin
            busy      = 1'b1;
            mem_ie    = we_q;
            mem_oe    = ~we_q;
            drive_bus = we_q;
         end
         ACK: begin
            busy = 1'b1;
            ack0 = ~g;
            ack1 = g;
         end
         default: ;
      endcase
   end

   assign bus = drive_bus ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level timing model checked every cycle,
// a small RAM on the shared bus, and directed scenarios with literal expectations.
module tb_memory_arbiter;

   localparam int MAX = 3;

   logic       clk;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       ack0, ack1, busy, mem_ie, mem_oe;
   logic [7:0] rdata, mem_addr;
   wire  [7:0] bus;

   memory_arbiter #(.MAX_STREAK(MAX)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_ie(mem_ie), .mem_oe(mem_oe), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: drives the bus while oe, writes on negedge while ie
   logic [7:0] ram [256];
   logic       ram_clr;
   assign bus = mem_oe ? ram[mem_addr] : 8'hzz;
   always @(negedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      end else if (mem_ie) begin
         ram[mem_addr] <= bus;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: a transaction occupies cycles t_start (access) and t_start+1 (ack)
   logic [7:0] mref [256];
   bit         valid = 0;
   bit         have_txn = 0;
   int         t_start, t_port;
   bit         t_we;
   logic [7:0] t_addr, t_data;
   logic [7:0] exp_addr = 8'h00, exp_rdata = 8'h00;
   int         streak_m = 0;
   int         slog[$];
   int         ack_port[$];
   int         ack_cyc[$];

   always @(negedge clk) begin
      bit in_acc, in_ack, bz;
      if (ram_clr) for (int i = 0; i < 256; i++) mref[i] = 8'h00;
      in_acc = have_txn && (cyc == t_start);
      in_ack = have_txn && (cyc == t_start + 1);
      if (valid) begin
         chk("ack0", ack0, int'(in_ack && t_port == 0));
         chk("ack1", ack1, int'(in_ack && t_port == 1));
         chk("busy", busy, int'(in_acc || in_ack));
         chk("mem_ie", mem_ie, int'(in_acc && t_we));
         chk("mem_oe", mem_oe, int'(in_acc && !t_we));
         chk("mem_addr", mem_addr, exp_addr);
         chk("rdata", rdata, exp_rdata);
         if (in_acc && t_we) begin
            chk("bus_wdata", bus, t_data);
         end else if (!in_acc) begin
            bz = (bus === 8'hzz);
            chk("bus_hiz", bz, 1);
         end
         if (ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
         if (ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
      end
      if (in_acc && t_we) mref[t_addr] = t_data;
      if (rst) begin
         have_txn  = 0;
         exp_addr  = 8'h00;
         exp_rdata = 8'h00;
         streak_m  = 0;
         valid     = 1;
      end else if (in_acc) begin
         if (!t_we) exp_rdata = mref[t_addr];
      end else if (in_ack) begin
         have_txn = 0;
      end else if (!have_txn && (req0 || req1)) begin
         t_port = (req1 && (!req0 || streak_m == MAX)) ? 1 : 0;
         slog.push_back(streak_m);
         if (t_port == 1 || !req1) streak_m = 0;
         else if (streak_m < MAX) streak_m++;
         t_we     = (t_port == 1) ? we1 : we0;
         t_addr   = (t_port == 1) ? addr1 : addr0;
         t_data   = (t_port == 1) ? wdata1 : wdata0;
         exp_addr = t_addr;
         have_txn = 1;
         t_start  = cyc + 1;
      end
      cyc++;
   end

   // single transaction; returns rdata seen in the ack cycle
   task automatic xact(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd);
      if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      chk("x_ie", mem_ie, int'(w));
      if (w) chk("x_bus", bus, d);
      @(posedge clk); #1;
      chk("x_ack", (p == 0) ? ack0 : ack1, 1);
      rd = rdata;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] rd;
      int a0, s0, n;
      int exp_ord[8];
      int exp_stk[5];
      exp_ord = '{0, 0, 0, 1, 0, 0, 0, 1};
      exp_stk = '{0, 1, 2, 3, 0};

      rst = 1; ram_clr = 1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0; ram_clr = 0;
      chk("rst_rdata", rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", mem_addr, 0);

      // port-0 write then read
      a0 = ack_port.size();
      xact(0, 1, 8'h10, 8'hA5, rd);
      xact(0, 0, 8'h10, 8'h00, rd);
      chk("p0_read", rd, 8'hA5);
      chk("p0_acks", ack_port.size() - a0, 2);
      chk("p0_ack_spacing", ack_cyc[a0 + 1] - ack_cyc[a0], 3);

      // port-1 back-to-back loader burst
      a0 = ack_port.size();
      req1 = 1; we1 = 1; addr1 = 8'h00; wdata1 = 8'h00;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i == 15) req1 = 0;
         else begin addr1 = 8'(i + 1); wdata1 = 8'(i + 1); end
         @(posedge clk);
         @(posedge clk);
      end
      #1;
      chk("burst_acks", ack_port.size() - a0, 16);
      for (int i = 1; i < 16; i++) begin
         chk("burst_port", ack_port[a0 + i], 1);
         chk("burst_spacing", ack_cyc[a0 + i] - ack_cyc[a0 + i - 1], 3);
      end
      for (int i = 0; i < 16; i++) begin
         xact(0, 0, 8'(i), 8'h00, rd);
         chk("burst_readback", rd, i);
      end

      // both ports requesting continuously
      a0 = ack_port.size();
      s0 = slog.size();
      req0 = 1; we0 = 0; addr0 = 8'h10;
      req1 = 1; we1 = 0; addr1 = 8'h03;
      repeat (22) @(posedge clk);
      #1 req0 = 0; req1 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("fair_acks", ack_port.size() - a0, 8);
      for (int i = 0; i < 8; i++) chk("fair_order", ack_port[a0 + i], exp_ord[i]);
      for (int i = 0; i < 5; i++) chk("fair_streak", slog[s0 + i], exp_stk[i]);

      // starvation bound: req1 rises in an idle cycle under continuous port-0 reads
      req0 = 1; we0 = 0; addr0 = 8'h05;
      repeat (6) @(posedge clk);
      #1 req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h77;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ack1) break;
      end
      req0 = 0; req1 = 0;
      chk("starve_latency", n, 11);
      chk("starve_bound", int'(n <= 3 * (MAX + 1)), 1);
      @(posedge clk); #1;
      xact(0, 0, 8'h40, 8'h00, rd);
      chk("starve_readback", rd, 8'h77);

      // reset during a port-0 write access
      req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h5A;
      @(posedge clk); #1;
      req0 = 0;
      chk("rstacc_ie", mem_ie, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rstacc_ack0", ack0, 0);
      chk("rstacc_rdata", rdata, 0);
      chk("rstacc_addr", mem_addr, 0);
      chk("rstacc_busy", busy, 0);
      chk("rstacc_oe", mem_oe, 0);
      chk("rstacc_hiz", int'(bus === 8'hzz), 1);
      @(posedge clk); #1;
      chk("rstacc_ack0_late", ack0, 0);
      chk("rstacc_ram", ram[8'h20], 8'h5A);

      // idle hygiene
      repeat (20) @(posedge clk);
      #1;
      chk("idle_rdata", rdata, 0);
      chk("idle_busy", busy, 0);
      xact(1, 0, 8'h20, 8'h00, rd);
      chk("rstacc_readback", rd, 8'h5A);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
